reg_display_scan: RTL and testbench

REG_DISPLAY_SCAN -- requirements
Module: reg_display_scan

---
 rtl/reg_display_scan_pkg.sv | 18 +
 rtl/reg_display_scan_if.sv | 25 ++
 rtl/reg_display_scan_hex7seg.sv | 11 +
 rtl/reg_display_scan.sv | 120 ++++++++++++
 tb/tb_reg_display_scan.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_display_scan_pkg.sv
// Shared types and constants for the multiplexed register display scanner.
// Holds the scan state encoding, the digit count and the seven-segment hex font.
package reg_display_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 9;

    // Segment order is gfedcba, active high.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/reg_display_scan_if.sv
// Bundle between the CPU register sources and the display scanner.
// No valid/ready handshake: all inputs are level-sampled every clk, and snap is asynchronous.
interface reg_display_scan_if;
    import reg_display_pkg::*;

    logic [3:0]  op;
    logic [3:0]  r0, r1, r2, r3, r4, r5, r6, r7;
    logic        freeze;
    logic        snap;
    logic [6:0]  seg;
    logic        dp;
    logic [8:0]  dig_n;
    scan_state_t state;

    modport master (
        output op, r0, r1, r2, r3, r4, r5, r6, r7, freeze, snap,
        input  seg, dp, dig_n, state
    );

    modport slave (
        input  op, r0, r1, r2, r3, r4, r5, r6, r7, freeze, snap,
        output seg, dp, dig_n, state
    );

endinterface

// File: rtl/reg_display_scan_hex7seg.sv
// Combinational hex digit to seven-segment pattern lookup.
module hex7seg_decoder
    import reg_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[hex];

endmodule

// File: rtl/reg_display_scan.sv
// Scans op and r0..r7 across nine multiplexed seven-segment digits, with a
// blanking gap between digits and a freeze/snapshot shadow register bank.
module reg_display_scan
    import reg_display_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 64
) (
    input logic               clk,
    input logic               rst_n,
    reg_display_scan_if.slave bus
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [3:0]    next_idx;
    logic [3:0]    shadow [NUM_DIGITS];
    logic [3:0]    live   [NUM_DIGITS];
    logic          snap_s1, snap_s2, snap_s3, snap_pulse;
    logic [6:0]    font_seg;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [8:0]    dig_n_q;

    always_comb begin
        live[0] = bus.op;
        live[1] = bus.r0;
        live[2] = bus.r1;
        live[3] = bus.r2;
        live[4] = bus.r3;
        live[5] = bus.r4;
        live[6] = bus.r5;
        live[7] = bus.r6;
        live[8] = bus.r7;
    end

    // Two-flop synchroniser, edge flop, then a registered pulse so a capture
    // lands three edges after the first edge that sees snap high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_s1    <= 1'b0;
            snap_s2    <= 1'b0;
            snap_s3    <= 1'b0;
            snap_pulse <= 1'b0;
        end else begin
            snap_s1    <= bus.snap;
            snap_s2    <= snap_s1;
            snap_s3    <= snap_s2;
            snap_pulse <= snap_s2 & ~snap_s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
        end else if (!bus.freeze || snap_pulse) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= live[i];
        end
    end

    assign next_idx = (idx == 4'(NUM_DIGITS - 1)) ? 4'd0 : idx + 4'd1;

    hex7seg_decoder u_font (
        .hex (shadow[next_idx]),
        .seg (font_seg)
    );

    // seg/dp are only reloaded on the last BLANK cycle, so shadow updates
    // during SHOW never reach the lit digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= 4'(NUM_DIGITS - 1);
            seg_q   <= '0;
            dp_q    <= 1'b0;
            dig_n_q <= '1;
        end else begin
            case (state)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state   <= BLANK;
                        cnt     <= '0;
                        dig_n_q <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state   <= SHOW;
                        cnt     <= '0;
                        idx     <= next_idx;
                        seg_q   <= font_seg;
                        dp_q    <= (next_idx == 4'd0);
                        dig_n_q <= ~(9'(1) << next_idx);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.dig_n = dig_n_q;
    assign bus.state = state;

endmodule

// File: tb/tb_reg_display_scan.sv
// Bench for reg_display_scan with PRESCALE=4, BLANK_CYC=2: directed scans with
// an expected-digit queue checked by a monitor at the start of every SHOW.
module tb_reg_display_scan;
    import reg_display_pkg::*;

    localparam int PRESCALE  = 4;
    localparam int BLANK_CYC = 2;

    logic clk;
    logic rst_n;

    reg_display_scan_if bus ();

    reg_display_scan #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [16:0] exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    logic [6:0] font_tb [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [3:0] ev [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_digit(input int d, input logic [3:0] v);
        logic [8:0] en;
        en = ~(9'b1 << d);
        exp_q.push_back({en, font_tb[v], (d == 0)});
    endtask

    task automatic push_scan();
        for (int d = 1; d < 9; d++) push_digit(d, ev[d]);
        push_digit(0, ev[0]);
    endtask

    task automatic wait_digit(input int d);
        logic [8:0] tgt;
        logic [8:0] prev;
        int         n;
        bit         seen;
        tgt  = ~(9'b1 << d);
        prev = bus.dig_n;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (bus.dig_n == tgt && prev != tgt) seen = 1'b1;
            prev = bus.dig_n;
            n++;
        end
        chk($sformatf("wait_digit%0d_timeout", d), {31'd0, seen}, 32'd1);
    endtask

    // monitor: pops one expectation per SHOW start and checks timing/stability
    int         show_len  = 0;
    int         blank_len = 0;
    bit         in_show   = 1'b0;
    logic [6:0] held_seg;
    logic       held_dp;

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            show_len  = 0;
            blank_len = 0;
            in_show   = 1'b0;
        end else if (bus.dig_n == 9'h1FF) begin
            if (in_show) begin
                chk("show_length", show_len, PRESCALE);
                in_show   = 1'b0;
                blank_len = 0;
            end
            blank_len++;
        end else begin
            chk("one_digit_active", $countones(bus.dig_n), 8);
            if (!in_show) begin
                chk("blank_length", blank_len, BLANK_CYC);
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_digit: got dig_n=%0h seg=%0h dp=%0b, expected none", bus.dig_n, bus.seg, bus.dp);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.dig_n, bus.seg, bus.dp} !== e) begin
                        mismatched++;
                        $display("FAIL digit_output: got dig_n=%0h seg=%0h dp=%0b, expected dig_n=%0h seg=%0h dp=%0b (t=%0t)",
                                 bus.dig_n, bus.seg, bus.dp, e[16:8], e[7:1], e[0], $time);
                    end
                end
                held_seg = bus.seg;
                held_dp  = bus.dp;
                in_show  = 1'b1;
                show_len = 0;
            end else begin
                chk("seg_stable_in_show", {bus.seg, bus.dp}, {held_seg, held_dp});
            end
            show_len++;
        end
    end

    // stimulus
    initial begin
        rst_n      = 1'b0;
        bus.op     = 4'd3;
        bus.r0     = 4'd0;
        bus.r1     = 4'd1;
        bus.r2     = 4'd2;
        bus.r3     = 4'd3;
        bus.r4     = 4'd4;
        bus.r5     = 4'd5;
        bus.r6     = 4'd6;
        bus.r7     = 4'd7;
        bus.freeze = 1'b0;
        bus.snap   = 1'b0;
        ev = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

        cyc(3);
        chk("reset_dig_n", bus.dig_n, 9'h1FF);
        chk("reset_seg", bus.seg, 7'h00);
        chk("reset_dp", bus.dp, 1'b0);
        chk("reset_state", bus.state, BLANK);

        push_digit(0, ev[0]);
        rst_n = 1'b1;

        // scan 1: plain walk through all nine digits
        wait_digit(0); cyc(1); push_scan();

        // freeze, then change r7 while digit 8 is lit
        wait_digit(8); cyc(1);
        bus.freeze = 1'b1;
        bus.r7     = 4'hF;

        // scan 2: snap held 10 cycles captures r7=F once; later r7=5 must not be captured
        wait_digit(0); cyc(1);
        ev[8] = 4'hF;
        push_scan();
        bus.snap = 1'b1;
        cyc(6);
        bus.r7 = 4'h5;
        cyc(4);
        bus.snap = 1'b0;

        // scan 3: live again; r0 changes mid-SHOW of digit 1
        wait_digit(0); cyc(1);
        bus.freeze = 1'b0;
        bus.r7     = 4'd7;
        ev[8]      = 4'd7;
        push_scan();
        wait_digit(1); cyc(2);
        bus.r0 = 4'd8;

        // scan 4: r0=8 now visible; reset hits during digit 5
        wait_digit(0); cyc(1);
        ev[1] = 4'd8;
        push_scan();
        wait_digit(5); cyc(2);
        rst_n = 1'b0;
        #1;
        chk("midreset_dig_n", bus.dig_n, 9'h1FF);
        chk("midreset_seg", bus.seg, 7'h00);
        chk("midreset_dp", bus.dp, 1'b0);
        exp_q.delete();
        cyc(3);
        push_digit(0, ev[0]);
        rst_n = 1'b1;

        // op sweep over all sixteen values on digit 0
        wait_digit(0); cyc(1);
        for (int v = 0; v < 16; v++) begin
            bus.op = 4'(v);
            ev[0]  = 4'(v);
            push_scan();
            wait_digit(0); cyc(1);
        end

        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
